// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice:
// FSM state encoding, parity-type constants and default frame width.
package uart_pkg;

    localparam int FRAME_DATA = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator for one UART frame.
// Ports: data (frame bits), par_typ (PAR_EVEN/PAR_ODD) -> parity bit.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int frame_data = FRAME_DATA
) (
    input  logic [frame_data-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    // Even parity makes the total count of ones even, so the bit is the
    // XOR reduction; odd parity is its complement.
    always_comb begin
        parity = ^data;
        if (par_typ == PAR_ODD) begin
            parity = ~parity;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, frame_data bits LSB first, optional
// parity, one stop bit; one bit per clk. Ports: clk, rst (sync, high),
// p_data/data_valid/par_en/par_typ in; tx_out (idle high), busy out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int frame_data = FRAME_DATA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [frame_data-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CW = (frame_data > 1) ? $clog2(frame_data) : 1;
    localparam logic [CW-1:0] LAST = CW'(frame_data - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [frame_data-1:0] data_q;
    logic [frame_data-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bit;

    // Parity always reflects the latched byte, never the live input.
    uart_parity_calc #(
        .frame_data(frame_data)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .parity  (par_bit)
    );

    // Outputs are produced together with the next state so that the
    // line value registered at each edge belongs to the state entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            data_q    <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    cnt    <= '0;
                    if (data_valid) begin
                        data_q    <= p_data;
                        shift_q   <= p_data;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        state     <= ST_START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    state   <= ST_DATA;
                    tx_out  <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    cnt     <= '0;
                end
                ST_DATA: begin
                    // cnt names the bit currently on the line.
                    if (cnt == LAST) begin
                        if (par_en_q) begin
                            state  <= ST_PARITY;
                            tx_out <= par_bit;
                        end else begin
                            state  <= ST_STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        tx_out  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                ST_PARITY: begin
                    state  <= ST_STOP;
                    tx_out <= 1'b1;
                end
                ST_STOP: begin
                    state  <= ST_IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    cnt    <= '0;
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: queue-based line model compared
// every cycle, plus directed literal frames and randomized traffic.
module tb_uart_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] p_data = '0;
    logic         data_valid = 1'b0;
    logic         par_en = 1'b0;
    logic         par_typ = 1'b0;
    logic         tx_out;
    logic         busy;

    int checks = 0;
    int passes = 0;
    bit checking = 1'b0;
    int cyc = 0;

    // Expected line bits still to appear, front = bit on the line now.
    bit line_q[$];

    uart_tx #(
        .frame_data(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic build_frame(input logic [W-1:0] d, input bit pen, input bit odd);
        int ones;
        bit pb;
        ones = $countones(d);
        line_q.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            line_q.push_back(d[i]);
        end
        if (pen) begin
            // Choose the bit so that ones+pb has the requested parity.
            pb = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
            line_q.push_back(pb);
        end
        line_q.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            line_q.delete();
        end else if (line_q.size() != 0) begin
            void'(line_q.pop_front());
        end else if (data_valid) begin
            build_frame(p_data, par_en, par_typ);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            logic exp_tx;
            logic exp_busy;
            exp_tx   = (line_q.size() != 0) ? line_q[0] : 1'b1;
            exp_busy = (line_q.size() != 0);
            checks++;
            if (tx_out !== exp_tx || busy !== exp_busy) begin
                $display("FAIL model cyc=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                         cyc, tx_out, busy, exp_tx, exp_busy);
            end else begin
                passes++;
            end
        end
    end

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic run_frame(input string name, input logic [W-1:0] d,
                             input bit pen, input bit pt,
                             input logic [10:0] exp_seq, input int nbits,
                             input int pulse_at);
        logic [10:0] seq;
        int bcnt;
        seq  = '0;
        bcnt = 0;
        @(negedge clk);
        p_data     = d;
        par_en     = pen;
        par_typ    = pt;
        data_valid = 1'b1;
        for (int i = 0; i <= nbits; i++) begin
            @(negedge clk);
            if (i < nbits) begin
                seq = {seq[9:0], tx_out};
            end else begin
                check_val({name, " idle_tx"}, int'(tx_out), 1);
                check_val({name, " idle_busy"}, int'(busy), 0);
            end
            bcnt += int'(busy);
            if (i == 0) begin
                data_valid = 1'b0;
                p_data     = ~d;
                par_en     = ~pen;
                par_typ    = ~pt;
            end
            if (pulse_at >= 0 && i == pulse_at) begin
                data_valid = 1'b1;
                p_data     = 8'hA5;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) begin
                data_valid = 1'b0;
            end
        end
        check_val({name, " bits"}, int'(seq), int'(exp_seq));
        check_val({name, " busy_len"}, bcnt, nbits);
        repeat (2) @(negedge clk);
    endtask

    task automatic spacing(input string name, input bit pen, input int exp_gap);
        int rises[$];
        logic prev;
        @(negedge clk);
        prev       = busy;
        p_data     = 8'h5A;
        par_en     = pen;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy && !prev) rises.push_back(i);
            prev   = busy;
            p_data = 8'($urandom);
        end
        data_valid = 1'b0;
        checks++;
        if (rises.size() < 2) begin
            $display("FAIL %s only %0d frames started, expected >=2", name, rises.size());
        end else begin
            passes++;
            check_val({name, " gap"}, rises[1] - rises[0], exp_gap);
        end
        repeat (14) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset tx_out", int'(tx_out), 1);
        check_val("reset busy", int'(busy), 0);
        rst      = 1'b0;
        checking = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("odd_55", 8'h55, 1'b1, 1'b1, 11'b01010101011, 11, -1);
        run_frame("even_ff", 8'hFF, 1'b1, 1'b0, 11'b01111111101, 11, -1);
        run_frame("nopar_00", 8'h00, 1'b0, 1'b0, 11'b00000000001, 10, -1);
        run_frame("ignore_3c", 8'h3C, 1'b1, 1'b0, 11'b00011110001, 11, 4);

        spacing("spacing_par", 1'b1, 12);
        spacing("spacing_nopar", 1'b0, 11);

        // Abort while data bit 4 of 0xC3 (a 0) is on the line.
        @(negedge clk);
        p_data     = 8'hC3;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i == 0) data_valid = 1'b0;
        end
        check_val("abort bit4", int'(tx_out), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort tx_out", int'(tx_out), 1);
        check_val("abort busy", int'(busy), 0);
        @(negedge clk);
        run_frame("c3_odd", 8'hC3, 1'b1, 1'b1, 11'b01100001111, 11, -1);

        // Reset and data_valid together: reset wins.
        @(negedge clk);
        rst        = 1'b1;
        data_valid = 1'b1;
        p_data     = 8'h81;
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;
        check_val("rst_vs_valid busy", int'(busy), 0);
        @(negedge clk);
        check_val("rst_vs_valid busy2", int'(busy), 0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 3) == 0);
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            rst        = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;
        repeat (15) @(negedge clk);

        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter frame_data, default 8: number of data bits per frame.
REQ-002 clk  input  1  single clock; one tx_out bit per clk cycle (baud clock).
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 p_data  input  frame_data  parallel byte to transmit.
REQ-005 data_valid  input  1  p_data, par_en and par_typ are valid this cycle.
REQ-006 par_en  input  1  1 = append a parity bit; 0 = no parity bit.
REQ-007 par_typ  input  1  1 = odd parity; 0 = even parity.
REQ-008 tx_out  output  1  serial line; idles high.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, tx_out SHALL be 1 and busy SHALL be 0.
REQ-012 A frame SHALL be accepted only on a rising clk edge where data_valid=1 and state=IDLE.
REQ-013 On acceptance, p_data, par_en and par_typ SHALL be latched; input changes during the frame SHALL have no effect.
REQ-014 data_valid while busy=1 SHALL be ignored, with no queuing.
REQ-015 Latency: on the cycle after the acceptance edge, state SHALL be START, tx_out=0 and busy=1.
REQ-016 DATA SHALL last exactly frame_data cycles and transmit the latched bits LSB first; the bit counter SHALL run 0..frame_data-1.
REQ-017 After DATA: if par_en is latched 1, the FSM SHALL go to PARITY, else directly to STOP.
REQ-018 PARITY SHALL last one cycle with tx_out = ^data when par_typ=0, or ~^data when par_typ=1.
REQ-019 STOP SHALL last one cycle with tx_out=1 and busy=1.
REQ-020 After STOP, the FSM SHALL return to IDLE.
REQ-021 Frame length SHALL be 11 cycles with parity, 10 without.
REQ-022 The minimum spacing between start bits SHALL be frame length + 1 cycle.
REQ-023 tx_out and busy SHALL be registered outputs with no combinational path from the inputs.
REQ-024 Simultaneous data_valid and rst: rst SHALL win and no frame is accepted.

Reset
REQ-025 On rst=1 at a clk edge: state SHALL be IDLE, tx_out=1, busy=0, bit counter=0 and the data/parity latches SHALL be cleared.
REQ-026 A reset mid-frame SHALL abort the frame immediately (tx_out=1 on the next cycle); no partial frame SHALL resume after reset.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state enum, the parity-type constants (PAR_EVEN=0, PAR_ODD=1) and the default frame_data.
REQ-028 Parity SHALL be computed in a sub-module uart_parity_calc (data, par_typ -> parity bit).
REQ-029 uart_parity_calc SHALL be evaluated on the latched data.
REQ-030 The implementation SHALL be a single FSM plus a serializer shift register/counter, with no FIFO.

Verification
REQ-031 Odd parity: par_en=1, par_typ=1, p_data=0x55 -> tx_out sequence 0,1,0,1,0,1,0,1,0,1,1; busy high for exactly 11 cycles.
REQ-032 Even parity: par_en=1, par_typ=0, p_data=0xFF -> 0,1,1,1,1,1,1,1,1,0,1.
REQ-033 No parity: par_en=0, p_data=0x00 -> 0, eight 0s, then 1; busy high for exactly 10 cycles.
REQ-034 Ignore while busy: data_valid pulsed with 0xA5 during frame 0x3C -> only 0x3C transmitted; the next frame is accepted only after busy=0.
REQ-035 Mid-frame reset: rst asserted during DATA bit 4 -> tx_out=1 and busy=0 on the next cycle; a subsequent 0xC3 frame is transmitted correctly.
REQ-036 Loopback: uart_tx output drives the existing receiver at prescale 8/16/32 with all 8 par_en/par_typ/data combinations -> received p_data matches; parity_error=0 and stop_error=0.
